// File: rtl/imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
// Holds the frame header byte, the default UART bit period, and the
// state encodings used by the loader FSM and the UART receiver.
package imem_loader_pkg;

   // First byte of every load frame; any other byte is ignored while idle.
   localparam logic [7:0] HEADER_BYTE = 8'h55;

   // 50 MHz system clock divided by 115200 baud.
   localparam int DEFAULT_CLKS_PER_BIT = 434;

   // Loader FSM encoding.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CNT_H  = 3'd1;
   localparam logic [2:0] ST_CNT_L  = 3'd2;
   localparam logic [2:0] ST_DATA_H = 3'd3;
   localparam logic [2:0] ST_DATA_L = 3'd4;
   localparam logic [2:0] ST_CHK    = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;
   localparam logic [2:0] ST_ERR    = 3'd7;

   // UART receiver encoding.
   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/imem_loader_if.sv
// Instruction-memory write port carried from the loader to the memory.
//   imem_we    : one-cycle write strobe
//   imem_addr  : word address, stable while imem_we is high
//   imem_wdata : 16-bit instruction word, stable while imem_we is high
// master = loader side (drives), slave = memory side (receives).
interface imem_loader_if #(
   parameter int ADDR_W = 12
);
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;

   modport master (output imem_we, output imem_addr, output imem_wdata);
   modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver, LSB first, idle high.
// Ports:
//   clk, reset (async, active-low)
//   rxd       : raw serial input (synchronised internally)
//   rxByte    : last received byte, valid with byteValid
//   byteValid : one-cycle pulse, byte received with a good stop bit
//   frameErr  : one-cycle pulse, stop bit sampled low (never with byteValid)
module uart_rx
   import imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] rxByte,
   output logic       byteValid,
   output logic       frameErr
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int HALF_BIT = CLKS_PER_BIT / 2;

   logic          rxMeta;
   logic          rxSync;
   logic          rxPrev;
   logic [1:0]    rxState;
   logic [TW-1:0] bitTimer;
   logic [2:0]    bitIdx;
   logic [7:0]    shiftReg;

   assign rxByte = shiftReg;

   // Two-flop synchroniser plus one history flop for falling-edge detection.
   // All three reset to the idle line level so reset release is not a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rxMeta <= 1'b1;
         rxSync <= 1'b1;
         rxPrev <= 1'b1;
      end else begin
         rxMeta <= rxd;
         rxSync <= rxMeta;
         rxPrev <= rxSync;
      end
   end

   // Bit-timing state machine. A falling edge starts the half-bit wait; the
   // start bit is confirmed at its centre so short glitches are dropped, then
   // every later sample lands one full bit period after the previous centre.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rxState   <= RX_IDLE;
         bitTimer  <= '0;
         bitIdx    <= '0;
         shiftReg  <= '0;
         byteValid <= 1'b0;
         frameErr  <= 1'b0;
      end else begin
         byteValid <= 1'b0;
         frameErr  <= 1'b0;
         case (rxState)
            RX_IDLE: begin
               if (rxPrev && !rxSync) begin
                  rxState  <= RX_START;
                  bitTimer <= '0;
               end
            end
            RX_START: begin
               if (bitTimer == TW'(HALF_BIT - 1)) begin
                  bitTimer <= '0;
                  bitIdx   <= '0;
                  rxState  <= rxSync ? RX_IDLE : RX_DATA;
               end else begin
                  bitTimer <= bitTimer + 1'b1;
               end
            end
            RX_DATA: begin
               if (bitTimer == TW'(CLKS_PER_BIT - 1)) begin
                  bitTimer <= '0;
                  shiftReg <= {rxSync, shiftReg[7:1]};
                  bitIdx   <= bitIdx + 3'd1;
                  if (bitIdx == 3'd7) begin
                     rxState <= RX_STOP;
                  end
               end else begin
                  bitTimer <= bitTimer + 1'b1;
               end
            end
            default: begin
               if (bitTimer == TW'(CLKS_PER_BIT - 1)) begin
                  bitTimer  <= '0;
                  rxState   <= RX_IDLE;
                  byteValid <= rxSync;
                  frameErr  <= !rxSync;
               end else begin
                  bitTimer <= bitTimer + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Serial boot loader: receives a framed program over UART and writes it into
// instruction memory while holding the processor in reset.
// Frame: 0x55, count hi, count lo, N x (word hi, word lo), checksum
// (checksum = XOR of the count and data bytes).
// Ports:
//   clk, reset (async, active-low)
//   rxd      : UART serial input
//   imem     : instruction-memory write port (master side)
//   cpu_hold : high while the processor must stay in reset
//   done     : high after a good load, until the next header
//   err      : high after a failed load, until the next header
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int ADDR_W       = 12
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          rxd,
   imem_loader_if.master imem,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);

   // Largest legal word count; 17 bits so ADDR_W = 16 still fits.
   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

   logic [7:0]        rxByte;
   logic              byteValid;
   logic              frameErr;
   logic [2:0]        state;
   logic [7:0]        countHi;
   logic [15:0]       wordTotal;
   logic [16:0]       wordCount;
   logic [16:0]       nextWordCount;
   logic [7:0]        dataHi;
   logic [7:0]        checksum;
   logic [15:0]       countWord;
   logic [ADDR_W-1:0] addrReg;
   logic [15:0]       wdataReg;
   logic              weReg;
   logic              advanceAddr;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk      (clk),
      .reset    (reset),
      .rxd      (rxd),
      .rxByte   (rxByte),
      .byteValid(byteValid),
      .frameErr (frameErr)
   );

   assign countWord     = {countHi, rxByte};
   assign nextWordCount = wordCount + 17'd1;

   assign imem.imem_we    = weReg;
   assign imem.imem_addr  = addrReg;
   assign imem.imem_wdata = wdataReg;

   // Loader FSM. The write strobe is raised the cycle after the low data byte
   // and the address moves on only once that strobe has been seen, so address
   // and data stay put for the whole write cycle. The last word of a frame
   // clears advanceAddr so a full-depth load never wraps back to address 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         countHi     <= '0;
         wordTotal   <= '0;
         wordCount   <= '0;
         dataHi      <= '0;
         checksum    <= '0;
         addrReg     <= '0;
         wdataReg    <= '0;
         weReg       <= 1'b0;
         advanceAddr <= 1'b0;
         cpu_hold    <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         weReg <= 1'b0;
         if (weReg && advanceAddr) begin
            addrReg <= addrReg + 1'b1;
         end
         if (frameErr) begin
            if (state != ST_IDLE && state != ST_DONE && state != ST_ERR) begin
               state <= ST_ERR;
               err   <= 1'b1;
               done  <= 1'b0;
            end
         end else if (byteValid) begin
            case (state)
               ST_IDLE, ST_DONE, ST_ERR: begin
                  if (rxByte == HEADER_BYTE) begin
                     state     <= ST_CNT_H;
                     done      <= 1'b0;
                     err       <= 1'b0;
                     cpu_hold  <= 1'b1;
                     addrReg   <= '0;
                     checksum  <= '0;
                     wordCount <= '0;
                  end
               end
               ST_CNT_H: begin
                  countHi  <= rxByte;
                  checksum <= checksum ^ rxByte;
                  state    <= ST_CNT_L;
               end
               ST_CNT_L: begin
                  wordTotal <= countWord;
                  checksum  <= checksum ^ rxByte;
                  if (countWord == 16'd0) begin
                     state <= ST_CHK;
                  end else if ({1'b0, countWord} > MAX_WORDS) begin
                     state <= ST_ERR;
                     err   <= 1'b1;
                  end else begin
                     state <= ST_DATA_H;
                  end
               end
               ST_DATA_H: begin
                  dataHi   <= rxByte;
                  checksum <= checksum ^ rxByte;
                  state    <= ST_DATA_L;
               end
               ST_DATA_L: begin
                  wdataReg  <= {dataHi, rxByte};
                  weReg     <= 1'b1;
                  checksum  <= checksum ^ rxByte;
                  wordCount <= nextWordCount;
                  if (nextWordCount == {1'b0, wordTotal}) begin
                     state       <= ST_CHK;
                     advanceAddr <= 1'b0;
                  end else begin
                     state       <= ST_DATA_H;
                     advanceAddr <= 1'b1;
                  end
               end
               ST_CHK: begin
                  if (rxByte == checksum) begin
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= ST_ERR;
                     err   <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
